// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative radix-2 multiply/divide unit with start/busy/done handshake
module alu_muldiv_seq #(
    parameter int WIDTH = 64
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [4:0]       iALUControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult
);
    localparam logic [4:0] OPMUL = 5'd16, OPMULH = 5'd17, OPMULHU = 5'd18, OPMULHSU = 5'd19;
    localparam logic [4:0] OPDIV = 5'd20, OPDIVU = 5'd21, OPREM = 5'd22, OPREMU = 5'd23;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

    stateT              state, nextState;
    logic [4:0]         op;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH:0]   acc;
    logic [CW-1:0]      count;
    logic               negRes, doneQ, accept;
    logic               isMul, isDiv, aNeg, bNeg, divZero, overflow, fast, opMul, opRem, ge;
    logic [WIDTH-1:0]   aMag, bMag, fastRes, fixRes;
    logic [WIDTH:0]     mulSum, divShift, divDiff;
    logic [2*WIDTH-1:0] prodS;

    // oDone is registered one cycle behind the DONE state so busy covers the pulse
    assign oBusy = (state != IDLE) || doneQ;
    assign oDone = doneQ;

    // Decode the incoming request: magnitudes, result sign and fast-path result
    always_comb begin
        isMul    = iALUControl inside {OPMUL, OPMULH, OPMULHU, OPMULHSU};
        isDiv    = iALUControl inside {OPDIV, OPDIVU, OPREM, OPREMU};
        aNeg     = iA[WIDTH-1] && (iALUControl inside {OPMULH, OPMULHSU, OPDIV, OPREM});
        bNeg     = iB[WIDTH-1] && (iALUControl inside {OPMULH, OPDIV, OPREM});
        aMag     = aNeg ? -iA : iA;
        bMag     = bNeg ? -iB : iB;
        divZero  = isDiv && (iB == '0);
        overflow = (iALUControl inside {OPDIV, OPREM}) && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (&iB);
        fast     = (!isMul && !isDiv) || divZero || overflow;
        fastRes  = divZero ? ((iALUControl inside {OPREM, OPREMU}) ? iA : '1)
                 : (overflow && iALUControl == OPDIV) ? iA : '0;
        accept   = iStart && !oBusy;
    end

    // One radix-2 step for the latched operation, plus sign fix-up and result selection
    always_comb begin
        opMul    = op inside {OPMUL, OPMULH, OPMULHU, OPMULHSU};
        opRem    = op inside {OPREM, OPREMU};
        mulSum   = acc[2*WIDTH:WIDTH] + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divDiff  = divShift - {1'b0, opnd};
        ge       = !divDiff[WIDTH];
        prodS    = negRes ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        fixRes   = (op == OPMUL) ? prodS[WIDTH-1:0]
                 : opMul ? prodS[2*WIDTH-1:WIDTH]
                 : opRem ? (negRes ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                 : (negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    end

    // State register
    always_ff @(posedge iCLK) begin
        if (iRST) state <= IDLE;
        else state <= nextState;
    end

    // Next-state logic: fast paths skip straight to DONE
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = accept ? (fast ? DONE : CALC) : IDLE;
            CALC:    nextState = (count == '0) ? FIX : CALC;
            FIX:     nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: latch on accept, shift-add or restoring divide in CALC, write result in FIX
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            doneQ   <= 1'b0;
            oResult <= '0;
        end else begin
            doneQ <= (state == DONE);
            if (accept) begin
                op     <= iALUControl;
                opnd   <= isMul ? aMag : bMag;
                acc    <= {{(WIDTH+1){1'b0}}, (isMul ? bMag : aMag)};
                count  <= CW'(WIDTH - 1);
                negRes <= aNeg ^ (bNeg && iALUControl != OPREM);
                if (fast) oResult <= fastRes;
            end else if (state == CALC) begin
                acc   <= opMul ? {1'b0, mulSum, acc[WIDTH-1:1]}
                               : {(ge ? divDiff : divShift), acc[WIDTH-2:0], ge};
                count <= count - 1'b1;
            end else if (state == FIX) begin
                oResult <= fixRes;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed vector table plus handshake corner cases for alu_muldiv_seq
module tb_alu_muldiv_seq;
    localparam int W = 64;
    localparam logic [4:0] OPNULL = 5'd0, OPADD = 5'd1;
    localparam logic [4:0] OPMUL = 5'd16, OPMULH = 5'd17, OPMULHU = 5'd18, OPMULHSU = 5'd19;
    localparam logic [4:0] OPDIV = 5'd20, OPDIVU = 5'd21, OPREM = 5'd22, OPREMU = 5'd23;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;
    localparam int SLOW = W + 2;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] want;
        int           lat;
    } vecT;

    logic         iCLK = 1'b0, iRST = 1'b1, iStart = 1'b0;
    logic [4:0]   iALUControl = '0;
    logic [W-1:0] iA = '0, iB = '0;
    logic         oBusy, oDone;
    logic [W-1:0] oResult;
    int           total = 0, bad = 0;
    vecT          vecs[23];

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iALUControl(iALUControl),
        .iA(iA), .iB(iB), .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic waitDone(output int n);
        n = 0;
        do begin
            @(posedge iCLK); #1;
            n++;
        end while (!oDone && n < 200);
    endtask

    task automatic runOp(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int n, output logic [W-1:0] res);
        @(negedge iCLK);
        iStart = 1'b1; iALUControl = op; iA = a; iB = b;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        waitDone(n);
        res = oResult;
        @(posedge iCLK); #1;
    endtask

    initial begin
        int n, n2;
        logic [W-1:0] res;
        vecs[0]  = '{OPMUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, SLOW};
        vecs[1]  = '{OPMULHU,  ONES,  ONES,  64'hFFFF_FFFF_FFFF_FFFE, SLOW};
        vecs[2]  = '{OPMULH,   ONES,  64'd1, ONES, SLOW};
        vecs[3]  = '{OPMULHSU, ONES,  ONES,  ONES, SLOW};
        vecs[4]  = '{OPDIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, SLOW};
        vecs[5]  = '{OPREM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, SLOW};
        vecs[6]  = '{OPDIVU,   64'd100, 64'd7, 64'd14, SLOW};
        vecs[7]  = '{OPREMU,   64'd100, 64'd7, 64'd2, SLOW};
        vecs[8]  = '{OPDIV,    64'd123, 64'd0, ONES, 1};
        vecs[9]  = '{OPREMU,   64'd5, 64'd0, 64'd5, 1};
        vecs[10] = '{OPDIVU,   64'd9, 64'd0, ONES, 1};
        vecs[11] = '{OPREM,    64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1};
        vecs[12] = '{OPDIV,    MIN, ONES, MIN, 1};
        vecs[13] = '{OPREM,    MIN, ONES, 64'd0, 1};
        vecs[14] = '{OPADD,    64'd3, 64'd4, 64'd0, 1};
        vecs[15] = '{OPNULL,   64'd5, 64'd6, 64'd0, 1};
        vecs[16] = '{OPMULH,   64'h4000_0000_0000_0000, 64'd4, 64'd1, SLOW};
        vecs[17] = '{OPMUL,    64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, SLOW};
        vecs[18] = '{OPDIV,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, SLOW};
        vecs[19] = '{OPREM,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, SLOW};
        vecs[20] = '{OPMULHSU, MIN, 64'd2, ONES, SLOW};
        vecs[21] = '{OPDIV,    MIN, 64'd2, 64'hC000_0000_0000_0000, SLOW};
        vecs[22] = '{OPDIVU,   ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, SLOW};

        repeat (2) @(posedge iCLK);
        #1;
        check("reset busy", W'(oBusy), '0);
        check("reset done", W'(oDone), '0);
        check("reset result", oResult, '0);
        @(negedge iCLK);
        iRST = 1'b0;

        for (int i = 0; i < 23; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, n, res);
            check($sformatf("vec%0d latency", i), W'(n), W'(vecs[i].lat));
            check($sformatf("vec%0d result", i), res, vecs[i].want);
        end

        @(negedge iCLK);
        iStart = 1'b1; iALUControl = OPMUL; iA = 64'd7; iB = 64'hFFFF_FFFF_FFFF_FFFD;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (10) @(posedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        @(posedge iCLK); #1;
        check("midcalc reset busy", W'(oBusy), '0);
        check("midcalc reset done", W'(oDone), '0);
        check("midcalc reset result", oResult, '0);
        @(negedge iCLK);
        iRST = 1'b0;
        runOp(OPMUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, n, res);
        check("post reset latency", W'(n), W'(SLOW));
        check("post reset result", res, 64'hFFFF_FFFF_FFFF_FFEB);

        @(negedge iCLK);
        iStart = 1'b1; iALUControl = OPDIVU; iA = 64'd100; iB = 64'd7;
        @(posedge iCLK); #1;
        n = 0;
        do begin
            @(negedge iCLK);
            iA = {$urandom, $urandom};
            @(posedge iCLK); #1;
            n++;
            if (n == 1) check("held start busy", W'(oBusy), W'(1));
        end while (!oDone && n < 200);
        iStart = 1'b0;
        check("held start latency", W'(n), W'(SLOW));
        check("held start result", oResult, 64'd14);
        @(posedge iCLK); #1;

        @(negedge iCLK);
        iStart = 1'b1; iALUControl = OPADD; iA = 64'd3; iB = 64'd4;
        @(posedge iCLK); #1;
        @(negedge iCLK);
        iALUControl = OPDIVU; iA = 64'd100; iB = 64'd7;
        waitDone(n);
        check("b2b first latency", W'(n), W'(1));
        check("b2b first result", oResult, '0);
        @(posedge iCLK); #1;
        check("b2b gap idle", W'(oBusy), '0);
        @(posedge iCLK); #1;
        iStart = 1'b0;
        check("b2b second accepted", W'(oBusy), W'(1));
        waitDone(n2);
        check("b2b second latency", W'(n2), W'(SLOW));
        check("b2b second result", oResult, 64'd14);
        @(posedge iCLK); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
